// File: rtl/tube_decoder.sv
// tube_decoder: recovers four multiplexed seven-segment digits and status from driver pins.
// Optional macro TUBE_DECODER_DP_EN adds decimal-point sampling and capture.
module tube_decoder #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned TIMEOUT       = 2000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] eight_seg,
   input  logic       seg0,
   input  logic       seg1,
   input  logic       seg2,
   input  logic       seg3,
   output logic [3:0] data0,
   output logic [3:0] data1,
   output logic [3:0] data2,
   output logic [3:0] data3,
   output logic [3:0] dp_out,
   output logic [3:0] digit_valid,
   output logic [3:0] blank,
   output logic       frame_valid,
   output logic       seg_err,
   output logic       anode_err,
   output logic       stale
);

`ifdef TUBE_DECODER_DP_EN
   localparam int unsigned SW = 12;
`else
   localparam int unsigned SW = 11;
`endif

   localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
   localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT);

   typedef enum logic {SETTLE, LOCKED} state_t;

   state_t        state;
   logic [SW-1:0] pins;
   logic [SW-1:0] sync_a;
   logic [SW-1:0] sample;
   logic [7:0]    stab_cnt;
   logic [31:0]   idle_cnt;
   logic [3:0]    seen;
   logic [3:0]    seen_base;
   logic [3:0]    data_r [4];
   logic [3:0]    anodes;
   logic [6:0]    seg_bits;
   logic [1:0]    idx;
   logic          changed;
   logic          accept;
   logic          one_anode;
   logic          no_anode;
   logic          dec_hit;
   logic [3:0]    dec_val;
   logic          is_blank;

`ifdef TUBE_DECODER_DP_EN
   assign pins = {eight_seg[7], seg3, seg2, seg1, seg0, eight_seg[6:0]};
`else
   logic dp_unused;
   assign dp_unused = eight_seg[7];
   assign pins      = {seg3, seg2, seg1, seg0, eight_seg[6:0]};
   assign dp_out    = 4'hF;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '1;
         sample <= '1;
      end else begin
         sync_a <= pins;
         sample <= sync_a;
      end
   end

   // Change is detected against the value about to enter the sample register,
   // which keeps the pin-to-output latency at 2 + STABLE_CYCLES clocks.
   assign changed   = (sync_a != sample);
   assign accept    = (state == SETTLE) && !changed && (stab_cnt == STABLE_MAX - 8'd1);
   assign anodes    = ~sample[10:7];
   assign seg_bits  = sample[6:0];
   assign one_anode = $onehot(anodes);
   assign no_anode  = (anodes == 4'b0000);
   assign is_blank  = (seg_bits == 7'h7F);
   assign seen_base = (seen == 4'hF) ? 4'h0 : seen;

   always_comb begin
      idx = 2'd0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (anodes[i]) idx = 2'(i);
      end
   end

   always_comb begin
      dec_hit = 1'b1;
      dec_val = 4'h0;
      case (seg_bits)
         7'h40: dec_val = 4'h0;
         7'h79: dec_val = 4'h1;
         7'h24: dec_val = 4'h2;
         7'h30: dec_val = 4'h3;
         7'h19: dec_val = 4'h4;
         7'h12: dec_val = 4'h5;
         7'h02: dec_val = 4'h6;
         7'h78: dec_val = 4'h7;
         7'h00: dec_val = 4'h8;
         7'h10: dec_val = 4'h9;
         7'h08: dec_val = 4'hA;
         7'h03: dec_val = 4'hB;
         7'h46: dec_val = 4'hC;
         7'h21: dec_val = 4'hD;
         7'h06: dec_val = 4'hE;
         7'h0E: dec_val = 4'hF;
         default: dec_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SETTLE;
         stab_cnt    <= '0;
         idle_cnt    <= '0;
         seen        <= '0;
         for (int unsigned i = 0; i < 4; i++) data_r[i] <= '0;
         digit_valid <= '0;
         blank       <= '0;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         anode_err   <= 1'b0;
         stale       <= 1'b0;
`ifdef TUBE_DECODER_DP_EN
         dp_out      <= 4'hF;
`endif
      end else begin
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         anode_err   <= 1'b0;

         if (changed) begin
            stab_cnt <= '0;
            state    <= SETTLE;
         end else if (stab_cnt != STABLE_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
         end

         if (seen == 4'hF) begin
            frame_valid <= 1'b1;
            seen        <= '0;
         end

         // Accept has priority over the timeout landing on the same cycle.
         if (accept) begin
            state    <= LOCKED;
            idle_cnt <= '0;
            stale    <= 1'b0;
            if (one_anode) begin
               if (dec_hit || is_blank) begin
                  if (dec_hit) data_r[idx] <= dec_val;
                  blank[idx]       <= is_blank;
                  digit_valid[idx] <= 1'b1;
                  seen             <= seen_base | (4'b0001 << idx);
`ifdef TUBE_DECODER_DP_EN
                  dp_out[idx]      <= sample[11];
`endif
               end else begin
                  seg_err <= 1'b1;
               end
            end else if (!no_anode) begin
               anode_err <= 1'b1;
            end
         end else if (idle_cnt == TIMEOUT_VAL - 32'd1) begin
            idle_cnt    <= TIMEOUT_VAL;
            stale       <= 1'b1;
            digit_valid <= '0;
            seen        <= '0;
         end else if (idle_cnt != TIMEOUT_VAL) begin
            idle_cnt <= idle_cnt + 32'd1;
         end
      end
   end

   assign data0 = data_r[0];
   assign data1 = data_r[1];
   assign data2 = data_r[2];
   assign data3 = data_r[3];

endmodule

// File: tb/tb_tube_decoder.sv
// Directed bench for tube_decoder: table of slot vectors plus latency, glitch,
// timeout and reset sequences.
module tb_tube_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] eight_seg;
   logic       seg0, seg1, seg2, seg3;
   logic [3:0] data0, data1, data2, data3;
   logic [3:0] dp_out, digit_valid, blank;
   logic       frame_valid, seg_err, anode_err, stale;

   int total = 0;
   int bad   = 0;
   int fv_n  = 0;
   int se_n  = 0;
   int ae_n  = 0;

   tube_decoder #(.STABLE_CYCLES(16), .TIMEOUT(1000)) dut (
      .clk(clk), .rst_n(rst_n), .eight_seg(eight_seg),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .dp_out(dp_out), .digit_valid(digit_valid), .blank(blank),
      .frame_valid(frame_valid), .seg_err(seg_err), .anode_err(anode_err),
      .stale(stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid) fv_n++;
         if (seg_err)     se_n++;
         if (anode_err)   ae_n++;
      end
   end

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  sg;
      logic        dp;
      logic [15:0] data;
      logic [3:0]  valid;
      logic [3:0]  blk;
      logic [3:0]  dpo;
      int          fv;
      int          se;
      int          ae;
   } vec_t;

   vec_t vt [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] sg, input logic dp);
      {seg3, seg2, seg1, seg0} = an;
      eight_seg = {dp, sg};
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exp_dp(input logic [3:0] v);
`ifdef TUBE_DECODER_DP_EN
      return v;
`else
      return 4'hF;
`endif
   endfunction

   initial begin
      int fv0, se0, ae0;

      vt[0]  = '{4'b1110, 7'h08, 1'b1, 16'h000A, 4'b0001, 4'b0000, 4'hF, 0, 0, 0};
      vt[1]  = '{4'b1101, 7'h03, 1'b1, 16'h00BA, 4'b0011, 4'b0000, 4'hF, 0, 0, 0};
      vt[2]  = '{4'b1011, 7'h46, 1'b0, 16'h0CBA, 4'b0111, 4'b0000, 4'hB, 0, 0, 0};
      vt[3]  = '{4'b0111, 7'h21, 1'b1, 16'hDCBA, 4'b1111, 4'b0000, 4'hB, 1, 0, 0};
      vt[4]  = '{4'b1110, 7'h40, 1'b1, 16'hDCB0, 4'b1111, 4'b0000, 4'hB, 0, 0, 0};
      vt[5]  = '{4'b1101, 7'h79, 1'b1, 16'hDC10, 4'b1111, 4'b0000, 4'hB, 0, 0, 0};
      vt[6]  = '{4'b1011, 7'h24, 1'b1, 16'hD210, 4'b1111, 4'b0000, 4'hF, 0, 0, 0};
      vt[7]  = '{4'b0111, 7'h30, 1'b1, 16'h3210, 4'b1111, 4'b0000, 4'hF, 1, 0, 0};
      vt[8]  = '{4'b1101, 7'h7F, 1'b1, 16'h3210, 4'b1111, 4'b0010, 4'hF, 0, 0, 0};
      vt[9]  = '{4'b1110, 7'h55, 1'b1, 16'h3210, 4'b1111, 4'b0010, 4'hF, 0, 1, 0};
      vt[10] = '{4'b1010, 7'h19, 1'b1, 16'h3210, 4'b1111, 4'b0010, 4'hF, 0, 0, 1};
      vt[11] = '{4'b1111, 7'h00, 1'b1, 16'h3210, 4'b1111, 4'b0010, 4'hF, 0, 0, 0};
      vt[12] = '{4'b1110, 7'h19, 1'b1, 16'h3214, 4'b1111, 4'b0010, 4'hF, 0, 0, 0};
      vt[13] = '{4'b1101, 7'h12, 1'b1, 16'h3254, 4'b1111, 4'b0000, 4'hF, 0, 0, 0};
      vt[14] = '{4'b1011, 7'h02, 1'b1, 16'h3654, 4'b1111, 4'b0000, 4'hF, 0, 0, 0};
      vt[15] = '{4'b0111, 7'h78, 1'b1, 16'h7654, 4'b1111, 4'b0000, 4'hF, 1, 0, 0};
      vt[16] = '{4'b1110, 7'h00, 1'b1, 16'h7658, 4'b1111, 4'b0000, 4'hF, 0, 0, 0};
      vt[17] = '{4'b1101, 7'h10, 1'b1, 16'h7698, 4'b1111, 4'b0000, 4'hF, 0, 0, 0};
      vt[18] = '{4'b1011, 7'h06, 1'b1, 16'h7E98, 4'b1111, 4'b0000, 4'hF, 0, 0, 0};
      vt[19] = '{4'b0111, 7'h0E, 1'b1, 16'hFE98, 4'b1111, 4'b0000, 4'hF, 1, 0, 0};

      rst_n = 1'b0;
      drive(4'b1111, 7'h7F, 1'b1);
      tick(3);
      check("rst_data",  {data3, data2, data1, data0}, 16'h0000);
      check("rst_dp",    dp_out, 4'hF);
      check("rst_valid", digit_valid, 4'h0);
      check("rst_blank", blank, 4'h0);
      check("rst_flags", {frame_valid, seg_err, anode_err, stale}, 4'h0);
      rst_n = 1'b1;
      tick(20);

      for (int i = 0; i < 20; i++) begin
         fv0 = fv_n; se0 = se_n; ae0 = ae_n;
         drive(vt[i].an, vt[i].sg, vt[i].dp);
         tick(40);
         check($sformatf("v%0d_data", i),  {data3, data2, data1, data0}, vt[i].data);
         check($sformatf("v%0d_valid", i), digit_valid, vt[i].valid);
         check($sformatf("v%0d_blank", i), blank, vt[i].blk);
         check($sformatf("v%0d_dp", i),    dp_out, exp_dp(vt[i].dpo));
         check($sformatf("v%0d_fv", i),    fv_n - fv0, vt[i].fv);
         check($sformatf("v%0d_se", i),    se_n - se0, vt[i].se);
         check($sformatf("v%0d_ae", i),    ae_n - ae0, vt[i].ae);
      end

      // Pin change to output update latency.
      drive(4'b1110, 7'h40, 1'b1);
      tick(17);
      check("lat_early", data0, 4'h8);
      tick(1);
      check("lat_hit", data0, 4'h0);
      tick(22);

      // Segments toggling faster than the stability window on digit 3.
      drive(4'b0111, 7'h21, 1'b1);
      tick(40);
      check("glitch_pre", data3, 4'hD);
      se0 = se_n;
      for (int k = 0; k < 8; k++) begin
         drive(4'b0111, (k % 2 == 0) ? 7'h24 : 7'h30, 1'b1);
         tick(10);
      end
      check("glitch_hold", data3, 4'hD);
      check("glitch_se", se_n - se0, 0);
      drive(4'b0111, 7'h0E, 1'b1);
      tick(40);
      check("glitch_post", data3, 4'hF);

      // Idle display: no anode low, then timeout.
      drive(4'b1111, 7'h7F, 1'b1);
      tick(18 + 999);
      check("to_before", stale, 1'b0);
      check("to_valid_before", digit_valid, 4'hF);
      tick(1);
      check("to_stale", stale, 1'b1);
      check("to_valid", digit_valid, 4'h0);
      check("to_data_kept", {data3, data2, data1, data0}, 16'hFE90);
      drive(4'b1110, 7'h79, 1'b1);
      tick(17);
      check("resume_early", stale, 1'b1);
      tick(1);
      check("resume_stale", stale, 1'b0);
      check("resume_data", data0, 4'h1);
      check("resume_valid", digit_valid, 4'b0001);

      // Reset asserted mid-settle.
      fv0 = fv_n; se0 = se_n; ae0 = ae_n;
      drive(4'b1101, 7'h24, 1'b1);
      tick(10);
      rst_n = 1'b0;
      #1;
      check("rst_mid_data", data0, 4'h0);
      check("rst_mid_valid", digit_valid, 4'h0);
      tick(2);
      rst_n = 1'b1;
      tick(40);
      check("post_rst_data", {data3, data2, data1, data0}, 16'h0020);
      check("post_rst_valid", digit_valid, 4'b0010);
      check("post_rst_pulses", (fv_n - fv0) + (se_n - se0) + (ae_n - ae0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tube_decoder.md
# tube_decoder

Receive-side counterpart of the four-digit multiplexed seven-segment driver: samples the active-low anode selects and segment bus, waits for each multiplexed slot to settle, and recovers the four 4-bit digit values and decimal points. It sits on board-to-board display links and in self-test loops, where it reads a driver's pins back into registers. It also flags blanking, illegal patterns, multiple anodes and a stalled scan.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a slot is accepted; legal range 2..255.
- TIMEOUT, 2000000: cycles without any accepted slot before the display is declared stale; 32-bit counter.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- eight_seg  in  8  [6:0] segments g..a, active-low; [7] decimal point, raw level.
- seg0, seg1, seg2, seg3  in  1 each  digit anode selects, active-low.
- data0, data1, data2, data3  out  4 each  last decoded value per digit.
- dp_out  out  4  last captured decimal-point level per digit, [i] for digit i.
- digit_valid  out  4  digit i has been captured since reset or the last timeout.
- blank  out  4  the last capture of digit i was the all-off pattern.
- frame_valid  out  1  one-cycle pulse when all four digits have been captured since the last pulse.
- seg_err  out  1  one-cycle pulse when a capture has an undecodable segment pattern.
- anode_err  out  1  one-cycle pulse when a capture has more than one anode low.
- stale  out  1  high from a timeout until the next accepted slot.

## Operation
- Inputs: all 12 inputs pass through 2-flop synchronizers. The synchronized vector is the sample.
- Stability counter (8-bit):
  - Cleared to 0 when the sample differs from the previous cycle's sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - An accept event fires only on the cycle the counter reaches STABLE_CYCLES, so there is one accept per stable period.
- FSM states:
  - SETTLE: counting. Goes to LOCKED on an accept event.
  - LOCKED: holds. Returns to SETTLE on any sample change.
  - Reset state is SETTLE.
- Accept event, anode handling:
  - No anode low: no capture and no error, but it still restarts the timeout.
  - More than one anode low: anode_err pulse; data is unchanged.
  - Exactly one anode low: the digit i is decoded.
- Decode of [6:0] (hex pattern → value):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7.
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - On a match: data_i ← value, blank[i] ← 0, digit_valid[i] ← 1.
  - 7F: blank[i] ← 1, digit_valid[i] ← 1, data_i unchanged.
  - Any other pattern: seg_err pulse, all digit outputs unchanged, digit not marked seen.
- Frame tracking:
  - A 4-bit seen mask sets bit i on every successful or blank capture of digit i.
  - When the mask becomes 1111, frame_valid pulses on the next cycle and the mask clears on that same cycle.
  - Repeated captures of one digit are harmless.
- Timeout:
  - The idle counter resets on every accept event and otherwise increments.
  - When it reaches TIMEOUT, on that cycle: stale ← 1, digit_valid ← 0, seen ← 0. Data and dp values are retained.
  - The next accept clears stale in the same cycle it captures.

## Timing
- Reset values of outputs:
  - Digit fields: data0..3 = 0, dp_out = 4'hF, digit_valid = 0, blank = 0.
  - Pulses and flags: frame_valid = 0, seg_err = 0, anode_err = 0, stale = 0.
- Reset values of internal state: FSM = SETTLE, counters = 0, seen = 0.
- Latency: a pin change that is then held constant updates the outputs exactly 2 + STABLE_CYCLES clocks later.
- Reset is asynchronous. Reset asserted mid-settle discards the partial count; no pulse is emitted.
- A sample change on the accept cycle itself is not possible, because accept requires the unchanged condition.
- Timeout and accept on the same cycle: the accept wins, so stale stays 0 and the timeout counter restarts.
- The frame_valid pulse may coincide with seg_err or anode_err from a later capture; the pulses are independent.
- An anode glitch shorter than STABLE_CYCLES is never captured.

## Configuration
- TUBE_DECODER_DP_EN defined:
  - Bit [7] is part of the sample and stability compare.
  - dp_out[i] ← eight_seg[7] on each capture of digit i.
- Not defined:
  - Bit [7] is not synchronized and is excluded from the compare.
  - dp_out is held at 4'hF.

## Test plan
- Drive segments 40, 79, 24, 30 in turn on seg0..seg3, each slot held 500 clocks, STABLE_CYCLES=16 → data = 0, 1, 2, 3; digit_valid = 1111; one frame_valid pulse per scan; the first update lands 18 clocks after the pin change.
- Hold seg1 low with segments 7F → blank[1] = 1, data1 retains its previous value, digit_valid[1] = 1.
- Slot with segments 55 → exactly one seg_err pulse and no output change. Slot with seg0 and seg2 both low → one anode_err pulse.
- Toggle segments every 10 clocks on seg3 (STABLE_CYCLES=16), then hold 0E → no capture during toggling; data3 = F after the hold.
- All anodes high for TIMEOUT=1000 clocks → stale rises on cycle 1000 and digit_valid = 0. Resume the scan → stale clears on the first capture.
- With TUBE_DECODER_DP_EN, eight_seg[7] = 0 on digit 2 → dp_out = 4'b1011. Without the macro → dp_out stays 4'hF.
